input_port_buffer: RTL and testbench
====================================

# input_port_buffer

Per-port input stage of the 5-port NoC router (L, N, E, S, W). Buffers incoming flits in a small FIFO, computes the XY route of each packet from its head flit, and presents a 3-bit direction request to the downstream `round_robin` arbiter. It holds that request for the whole packet (wormhole lock) and drains one flit per cycle while granted. One instance sits in front of each arbiter request input.

## Interface
- `DATA_W`, 32: flit width; bits [DATA_W-1:DATA_W-2] are the flit type.
- `DEPTH`, 4: FIFO depth in flits; power of two, minimum 2.
- `COORD_W`, 2: coordinate width; head flit dest_x = [2*COORD_W-1:COORD_W], dest_y = [COORD_W-1:0].
- `CUR_X`, 0: this router's X coordinate.
- `CUR_Y`, 0: this router's Y coordinate.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream flit valid.
- `in_data`  in  DATA_W  upstream flit.
- `in_ready`  out  1  buffer can accept; equals !full.
- `grant`  in  1  arbiter has selected this port this cycle.
- `request`  out  3  route request: 000 none, 001 L, 010 N, 011 E, 100 S, 101 W.
- `out_valid`  out  1  flit at `out_data` is valid for the crossbar.
- `out_data`  out  DATA_W  FIFO front flit.
- `err`  out  1  malformed-flit pulse (see Configuration).

## Operation
- Flit types: 01 head, 00 body, 10 tail, 11 single (head+tail).
- FIFO: circular buffer, read/write pointers of log2(DEPTH) bits, occupancy counter of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push on rising edge when in_valid && in_ready. A push is refused while full, even in a cycle that also pops.
- The XY route is computed combinationally from the front flit:
  - dest_x > CUR_X → E; dest_x < CUR_X → W.
  - Otherwise dest_y > CUR_Y → S; dest_y < CUR_Y → N.
  - Otherwise → L.
- FSM states IDLE and ACTIVE:
  - IDLE: `request` = 000. If front is non-empty with type head or single, latch the route into `request` and go to ACTIVE.
  - ACTIVE: `request` is held constant. out_valid = !empty. Pop on each edge where grant && !empty.
  - Popping a tail or single flit returns to IDLE and clears `request` to 000 on the same edge.
- `out_data` always shows the FIFO front, with no register stage.
- `grant` while in IDLE or empty is ignored: no pop occurs.

## Timing
- Reset values: `request` = 000, out_valid = 0, in_ready = 1, err = 0, out_data = 0, FIFO empty, state IDLE.
- Write-to-front latency: a flit pushed at edge k is at the front after edge k (visible in cycle k+1).
- Head at front in IDLE during cycle k → `request` valid from edge k+1.
- Minimum ingress-to-request latency is 2 edges.
- Throughput: one flit per granted cycle. Back-to-back packets incur 1 IDLE cycle between a tail pop and the next request.
- Simultaneous push and pop when not full: occupancy is unchanged and both pointers advance.
- Empty mid-packet in ACTIVE: out_valid = 0, `request` held, and the state stays ACTIVE until the tail drains.
- Reset mid-packet flushes the FIFO asynchronously and drops the packet; all outputs return to their reset values immediately.

## Configuration
- `IBUF_ERR_CHECK_EN` defined: in IDLE, a body or tail flit at the front is malformed.
  - It is popped without asserting `request`.
  - `err` pulses high for exactly 1 cycle (registered, on the edge after the drop).
- `IBUF_ERR_CHECK_EN` undefined:
  - `err` is tied to 0.
  - A body or tail flit at the front in IDLE is treated as a head: routed from its dest bits. A tail type then terminates the packet after 1 flit.

## Test plan
- Reset then a single flit with dest (0,0) at CUR (0,0): `request` = 001 two edges after push; pop on grant; `request` = 000 on the same edge.
- Head with dest_x > CUR_X followed by 2 bodies and a tail, grant held high: `request` = 011 for 4 cycles; out_data sequence matches input order; IDLE afterwards.
- Fill DEPTH = 4 with no grant: in_ready = 0 after the 4th push; a 5th in_valid is not accepted. Then push and pop in the same cycle while full: the push is refused and occupancy becomes 3.
- Grant toggling 1/0 during a 6-flit packet with a pointer wrap: no flit lost or duplicated; `request` stays stable until the tail.
- Assert rst mid-packet with 3 flits buffered: immediately `request` = 000, out_valid = 0, in_ready = 1; the next head is routed normally.
- With `IBUF_ERR_CHECK_EN`: a body flit arrives while IDLE → it is dropped, `err` pulses 1 cycle, `request` stays 000.

Source files
------------

// File: rtl/input_port_buffer_if.sv
// Router input-port bundle: upstream flit ingress, arbiter request/grant and crossbar egress.
interface input_port_buffer_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              grant;
  logic [2:0]        request;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              err;

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, request, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, request, out_valid, out_data, err
  );
endinterface

// File: rtl/input_port_buffer.sv
// NoC router input stage: flit FIFO, XY route from the packet head, wormhole-locked request.
// Defining IBUF_ERR_CHECK_EN drops stray body/tail flits seen in IDLE and pulses err.
module input_port_buffer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input_port_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_W-1:0] LP_CUR_X = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] LP_CUR_Y = COORD_W'(CUR_Y);
  localparam logic [2:0] REQ_NONE = 3'b000;
  localparam logic [2:0] REQ_L    = 3'b001;
  localparam logic [2:0] REQ_N    = 3'b010;
  localparam logic [2:0] REQ_E    = 3'b011;
  localparam logic [2:0] REQ_S    = 3'b100;
  localparam logic [2:0] REQ_W    = 3'b101;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  // X first, then Y; equal coordinates deliver locally.
  function automatic logic [2:0] xy_route(input logic [2*COORD_W-1:0] dest);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [2:0]         dir;
    dx = dest[2*COORD_W-1:COORD_W];
    dy = dest[COORD_W-1:0];
    if (dx > LP_CUR_X)      dir = REQ_E;
    else if (dx < LP_CUR_X) dir = REQ_W;
    else if (dy > LP_CUR_Y) dir = REQ_S;
    else if (dy < LP_CUR_Y) dir = REQ_N;
    else                    dir = REQ_L;
    return dir;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  logic [2:0]        r_request;

  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_front;
  logic [1:0]        w_type;
  logic              w_is_head;
  logic              w_is_last;
  logic [2:0]        w_route;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;

  assign w_empty   = (r_count == CNT_W'(0));
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_front   = r_mem[r_rd_ptr];
  assign w_type    = w_front[DATA_W-1:DATA_W-2];
  assign w_is_head = (w_type == 2'b01) || (w_type == 2'b11);
  assign w_is_last = (w_type == 2'b10) || (w_type == 2'b11);
  assign w_route   = xy_route(w_front[2*COORD_W-1:0]);

`ifdef IBUF_ERR_CHECK_EN
  assign w_drop = (r_state == ST_IDLE) && !w_empty && !w_is_head;
`else
  assign w_drop = 1'b0;
`endif

  // A full buffer refuses the push even when the same edge pops.
  assign w_push = bus.in_valid && !w_full;
  assign w_pop  = ((r_state == ST_ACTIVE) && bus.grant && !w_empty) || w_drop;

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = (r_state == ST_ACTIVE) && !w_empty;
  assign bus.out_data  = w_front;
  assign bus.request   = r_request;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.in_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Wormhole lock: request latched from the head and held until the last flit pops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_request <= REQ_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && !w_drop) begin
            r_request <= w_route;
            r_state   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (bus.grant && !w_empty && w_is_last) begin
            r_request <= REQ_NONE;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_request <= REQ_NONE;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IBUF_ERR_CHECK_EN
  logic r_err;

  // One-cycle pulse on the edge that discards a malformed flit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_drop;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (1,1) with a 4-deep FIFO.
module tb_input_port_buffer;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  input_port_buffer_if #(.DATA_W(32)) bus ();

  input_port_buffer #(
    .DATA_W(32), .DEPTH(4), .COORD_W(2), .CUR_X(1), .CUR_Y(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                     input logic [1:0] dy, input logic [25:0] pl);
    return {t, pl, dx, dy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.grant    = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.request !== 3'b000) begin n_bad++; $display("FAIL rst_request: got %b expected 000", bus.request); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", bus.err); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] f;
    f = mk(T_SGL, 2'd1, 2'd1, 26'h0A1);
    bus.in_valid = 1'b1;
    bus.in_data  = f;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.request !== 3'b000) begin n_bad++; $display("FAIL single_req_early: got %b expected 000", bus.request); end
    tick();
    n_cmp++; if (bus.request !== 3'b001) begin n_bad++; $display("FAIL single_req: got %b expected 001", bus.request); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== f) begin n_bad++; $display("FAIL single_out: got v=%b d=%h expected v=1 d=%h", bus.out_valid, bus.out_data, f); end
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL single_release: got req=%b v=%b expected req=000 v=0", bus.request, bus.out_valid); end
  endtask

  task automatic test_packet();
    logic [31:0] pk [4];
    pk[0] = mk(T_HEAD, 2'd3, 2'd0, 26'h100);
    pk[1] = mk(T_BODY, 2'd0, 2'd0, 26'h101);
    pk[2] = mk(T_BODY, 2'd2, 2'd3, 26'h102);
    pk[3] = mk(T_TAIL, 2'd1, 2'd1, 26'h103);
    bus.grant = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h0;
      if (s <= 4) begin
        bus.in_valid = 1'b1;
        bus.in_data  = pk[s-1];
      end
      tick();
      if (s >= 2 && s <= 5) begin
        n_cmp++; if (bus.request !== 3'b011) begin n_bad++; $display("FAIL packet_req[%0d]: got %b expected 011", s, bus.request); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== pk[s-2]) begin n_bad++; $display("FAIL packet_data[%0d]: got v=%b d=%h expected v=1 d=%h", s, bus.out_valid, bus.out_data, pk[s-2]); end
      end else begin
        n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL packet_idle[%0d]: got req=%b v=%b expected req=000 v=0", s, bus.request, bus.out_valid); end
      end
    end
    bus.in_valid = 1'b0;
    bus.grant    = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    a = mk(T_SGL, 2'd1, 2'd1, 26'h200);
    b = mk(T_SGL, 2'd0, 2'd1, 26'h201);
    bus.grant    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    tick();
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.request !== 3'b001 || bus.out_data !== a) begin n_bad++; $display("FAIL b2b_first: got req=%b d=%h expected req=001 d=%h", bus.request, bus.out_data, a); end
    tick();
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0 || bus.out_data !== b) begin n_bad++; $display("FAIL b2b_gap: got req=%b v=%b d=%h expected req=000 v=0 d=%h", bus.request, bus.out_valid, bus.out_data, b); end
    tick();
    n_cmp++; if (bus.request !== 3'b101 || bus.out_valid !== 1'b1 || bus.out_data !== b) begin n_bad++; $display("FAIL b2b_second: got req=%b v=%b d=%h expected req=101 v=1 d=%h", bus.request, bus.out_valid, bus.out_data, b); end
    tick();
    bus.grant = 1'b0;
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got req=%b v=%b expected req=000 v=0", bus.request, bus.out_valid); end
  endtask

  task automatic test_full();
    logic [31:0] f [5];
    f[0] = mk(T_HEAD, 2'd1, 2'd0, 26'h300);
    f[1] = mk(T_BODY, 2'd0, 2'd0, 26'h301);
    f[2] = mk(T_BODY, 2'd0, 2'd0, 26'h302);
    f[3] = mk(T_BODY, 2'd0, 2'd0, 26'h303);
    f[4] = mk(T_TAIL, 2'd0, 2'd0, 26'h304);
    bus.grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = f[i];
      tick();
    end
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.request !== 3'b010) begin n_bad++; $display("FAIL full_flag: got rdy=%b req=%b expected rdy=0 req=010", bus.in_ready, bus.request); end
    bus.in_data = f[4];
    tick();
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_data !== f[0]) begin n_bad++; $display("FAIL full_refuse: got rdy=%b d=%h expected rdy=0 d=%h", bus.in_ready, bus.out_data, f[0]); end
    bus.grant = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_data !== f[1]) begin n_bad++; $display("FAIL full_pushpop: got rdy=%b d=%h expected rdy=1 d=%h", bus.in_ready, bus.out_data, f[1]); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== f[2]) begin n_bad++; $display("FAIL full_drain2: got v=%b d=%h expected v=1 d=%h", bus.out_valid, bus.out_data, f[2]); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== f[3]) begin n_bad++; $display("FAIL full_drain3: got v=%b d=%h expected v=1 d=%h", bus.out_valid, bus.out_data, f[3]); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.request !== 3'b010) begin n_bad++; $display("FAIL empty_midpkt: got v=%b req=%b expected v=0 req=010", bus.out_valid, bus.request); end
    bus.in_valid = 1'b1;
    bus.in_data  = f[4];
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== f[4] || bus.request !== 3'b010) begin n_bad++; $display("FAIL full_tail: got v=%b d=%h req=%b expected v=1 d=%h req=010", bus.out_valid, bus.out_data, bus.request, f[4]); end
    tick();
    bus.grant = 1'b0;
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_end: got req=%b v=%b expected req=000 v=0", bus.request, bus.out_valid); end
  endtask

  task automatic test_grant_toggle();
    logic [31:0] pk [6];
    int np;
    int nexp;
    int cyc;
    int req_bad;
    bit req_seen;
    pk[0] = mk(T_HEAD, 2'd0, 2'd1, 26'h400);
    for (int i = 1; i < 5; i++) begin
      pk[i] = mk(T_BODY, 2'(i), 2'(i + 1), 26'(32'h400 + 32'(i)));
    end
    pk[5] = mk(T_TAIL, 2'd3, 2'd3, 26'h405);
    np = 0; nexp = 0; cyc = 0; req_bad = 0; req_seen = 1'b0;
    while (nexp < 6 && cyc < 60) begin
      bus.in_valid = (np < 6);
      bus.in_data  = (np < 6) ? pk[np] : 32'h0;
      bus.grant    = cyc[0];
      if (bus.request !== 3'b000) req_seen = 1'b1;
      if (req_seen && bus.request !== 3'b101) req_bad++;
      if (bus.grant && bus.out_valid) begin
        n_cmp++; if (bus.out_data !== pk[nexp]) begin n_bad++; $display("FAIL toggle_data[%0d]: got %h expected %h", nexp, bus.out_data, pk[nexp]); end
        nexp++;
      end
      if (bus.in_valid && bus.in_ready) np++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.grant    = 1'b0;
    n_cmp++; if (nexp != 6) begin n_bad++; $display("FAIL toggle_timeout: got %0d flits expected 6", nexp); end
    n_cmp++; if (req_bad != 0) begin n_bad++; $display("FAIL toggle_req_stable: got %0d unstable cycles expected 0", req_bad); end
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL toggle_end: got req=%b v=%b expected req=000 v=0", bus.request, bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    bus.grant    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = mk(T_HEAD, 2'd1, 2'd2, 26'h500);
    tick();
    bus.in_data  = mk(T_BODY, 2'd0, 2'd0, 26'h501);
    tick();
    bus.in_data  = mk(T_BODY, 2'd0, 2'd0, 26'h502);
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.request !== 3'b100 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got req=%b v=%b expected req=100 v=1", bus.request, bus.out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_async: got req=%b v=%b rdy=%b expected req=000 v=0 rdy=1", bus.request, bus.out_valid, bus.in_ready); end
    n_cmp++; if (bus.out_data !== 32'h0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL midrst_data: got d=%h err=%b expected d=0 err=0", bus.out_data, bus.err); end
    #1;
    rst = 1'b0;
    s = mk(T_SGL, 2'd2, 2'd2, 26'h510);
    bus.in_valid = 1'b1;
    bus.in_data  = s;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (bus.request !== 3'b011 || bus.out_data !== s) begin n_bad++; $display("FAIL midrst_next: got req=%b d=%h expected req=011 d=%h", bus.request, bus.out_data, s); end
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_end: got req=%b v=%b expected req=000 v=0", bus.request, bus.out_valid); end
  endtask

`ifdef IBUF_ERR_CHECK_EN
  task automatic test_stray_flit();
    logic [31:0] s;
    int errs;
    int req_bad;
    errs = 0; req_bad = 0;
    bus.grant    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = mk(T_BODY, 2'd2, 2'd1, 26'h600);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.err === 1'b1) errs++;
      if (bus.request !== 3'b000) req_bad++;
      tick();
    end
    n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL err_pulse: got %0d high cycles expected 1", errs); end
    n_cmp++; if (req_bad != 0) begin n_bad++; $display("FAIL err_no_req: got %0d requesting cycles expected 0", req_bad); end
    s = mk(T_SGL, 2'd1, 2'd1, 26'h610);
    bus.in_valid = 1'b1;
    bus.in_data  = s;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (bus.request !== 3'b001 || bus.out_data !== s) begin n_bad++; $display("FAIL err_after: got req=%b d=%h expected req=001 d=%h", bus.request, bus.out_data, s); end
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
  endtask
`else
  task automatic test_stray_flit();
    logic [31:0] t;
    t = mk(T_TAIL, 2'd2, 2'd1, 26'h600);
    bus.grant    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = t;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_cmp++; if (bus.request !== 3'b011 || bus.out_data !== t || bus.err !== 1'b0) begin n_bad++; $display("FAIL stray_as_head: got req=%b d=%h err=%b expected req=011 d=%h err=0", bus.request, bus.out_data, bus.err, t); end
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
    n_cmp++; if (bus.request !== 3'b000 || bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL stray_tail_end: got req=%b v=%b err=%b expected req=000 v=0 err=0", bus.request, bus.out_valid, bus.err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_packet();
    test_back_to_back();
    test_full();
    test_grant_toggle();
    test_reset_mid();
    test_stray_flit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
